// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: loader state encoding, opcode constants and default widths.
package sap_pkg;

   localparam int SAP_ADDR_W = 4;
   localparam int SAP_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      CHECK = 3'd4,
      ERR   = 3'd5
   } state_e;

   localparam logic [3:0] OP_LDA = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_OUT = 4'd14;
   localparam logic [3:0] OP_HLT = 4'd15;

   // Packs an opcode and a 4-bit operand into one SAP-1 instruction byte.
   function automatic logic [7:0] sap_instr(input logic [3:0] op, input logic [3:0] operand);
      return {op, operand};
   endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a program image into the SAP-1 RAM and holds the CPU in reset while loading.
// Optional trailing-checksum verification is enabled by defining CHECKSUM_EN.
module prog_loader
   import sap_pkg::*;
#(
   parameter int ADDR_W = SAP_ADDR_W,
   parameter int DATA_W = SAP_DATA_W,
   parameter int WORDS  = 16          // 1 <= WORDS <= 2**ADDR_W
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              cpu_res,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              in_ready_q;
   logic              ram_we_q;
   logic              busy_q;
   logic              done_q;
   logic              accept_s;

`ifdef CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [DATA_W-1:0] sum_chk_s;
   logic              err_q;

   assign sum_chk_s = sum_q + in_data;
`endif

   assign accept_s = in_valid & in_ready_q;

   // Next-state, address counter, data capture and checksum accumulation.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
`ifdef CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               addr_d  = '0;
`ifdef CHECKSUM_EN
               sum_d   = '0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (accept_s) begin
               state_d = WRITE;
               data_d  = in_data;
`ifdef CHECKSUM_EN
               sum_d   = sum_chk_s;
`endif
            end else begin
               state_d = LOAD;
            end
         end
         WRITE: begin
            // The counter parks on the last word; only a new start clears it.
            if (addr_q == LAST_ADDR) begin
`ifdef CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = DONE;
`endif
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = LOAD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
`ifdef CHECKSUM_EN
         CHECK: begin
            if (accept_s) begin
               state_d = (sum_chk_s == '0) ? DONE : ERR;
            end else begin
               state_d = CHECK;
            end
         end
         ERR: begin
            if (start) begin
               state_d = LOAD;
               addr_d  = '0;
               sum_d   = '0;
            end else begin
               state_d = ERR;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and data registers.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Outputs are decoded from the next state so they leave a flop aligned with the state.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         in_ready_q <= 1'b0;
         ram_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         in_ready_q <= (state_d == LOAD) || (state_d == CHECK);
         ram_we_q   <= (state_d == WRITE);
         busy_q     <= (state_d == LOAD) || (state_d == WRITE) || (state_d == CHECK);
         done_q     <= (state_d == DONE);
      end
   end

`ifdef CHECKSUM_EN
   // Running image checksum and sticky error flag.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         err_q <= (state_d == ERR);
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign in_ready  = in_ready_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   // Kept combinational so the CPU is in reset for the whole loader reset too.
   assign cpu_res   = res | (state_q != IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes and done pulses are queued by
// the stimulus and retired by an independent negedge monitor.
module tb_prog_loader;
   import sap_pkg::*;

   logic       clk = 1'b0;
   logic       res;
   logic       start, in_valid;
   logic [7:0] in_data;
   logic       in_ready, ram_we, cpu_res, busy, done, err;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;

   logic       o_start, o_in_valid;
   logic [7:0] o_in_data;
   logic       o_in_ready, o_ram_we, o_cpu_res, o_busy, o_done, o_err;
   logic [3:0] o_ram_addr;
   logic [7:0] o_ram_wdata;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        sb_q[$];
   wr_t        exp_wr;
   int         exp_done = 0;
   bit         post_done = 1'b0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] img[16];

   always #5 clk = ~clk;

   prog_loader u_dut (
      .clk(clk), .res(res), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .cpu_res(cpu_res), .busy(busy), .done(done), .err(err)
   );

   prog_loader #(.ADDR_W(4), .DATA_W(8), .WORDS(1)) u_one (
      .clk(clk), .res(res), .start(o_start), .in_valid(o_in_valid), .in_data(o_in_data),
      .in_ready(o_in_ready), .ram_we(o_ram_we), .ram_addr(o_ram_addr), .ram_wdata(o_ram_wdata),
      .cpu_res(o_cpu_res), .busy(o_busy), .done(o_done), .err(o_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: retire RAM writes and done pulses against the scoreboard.
   always @(negedge clk) begin
      if (post_done) begin
         chk("cpu_res_after_done", cpu_res, 1'b0);
         post_done = 1'b0;
      end
      if (ram_we === 1'b1) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_we: addr 0x%0h data 0x%0h, want no write", ram_addr, ram_wdata);
         end else begin
            exp_wr = sb_q.pop_front();
            chk("we_addr", ram_addr, exp_wr.a);
            chk("we_data", ram_wdata, exp_wr.d);
         end
      end
      if (done === 1'b1) begin
         n_cmp++;
         if (exp_done == 0) begin
            n_err++;
            $display("FAIL unexpected_done: done=1, want 0 at %0t", $time);
         end else begin
            exp_done--;
            chk("done_cpu_res", cpu_res, 1'b1);
            post_done = 1'b1;
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_cpu_res", cpu_res, 1'b1);
      chk("start_in_ready", in_ready, 1'b1);
      chk("start_addr", ram_addr, 4'd0);
      chk("start_err", err, 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit push, input logic [3:0] a);
      int n;
      if (push) sb_q.push_back('{a: a, d: b});
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("ready_timeout", n, 0);
      @(posedge clk); #1;
      chk("ready_drop", in_ready, 1'b0);
   endtask

   // Loads all 16 words (plus checksum byte when enabled) after a start has been issued.
   task automatic load_full(input int stall_at, input int glitch_at, input logic [7:0] cks,
                            input bit ok);
      for (int i = 0; i < 16; i++) begin
         if (i == stall_at) begin
            in_valid = 1'b0;
            repeat (5) begin
               @(posedge clk); #1;
               chk("stall_ready", in_ready, 1'b1);
               chk("stall_addr", ram_addr, 4'(stall_at));
               chk("stall_busy", busy, 1'b1);
            end
         end
         if (i == glitch_at) begin
            in_valid = 1'b0;
            start = 1'b1;
            repeat (2) @(posedge clk);
            #1 start = 1'b0;
            chk("glitch_addr", ram_addr, 4'(glitch_at));
         end
`ifndef CHECKSUM_EN
         if (i == 15) exp_done++;
`endif
         send_byte(img[i], 1'b1, 4'(i));
      end
`ifdef CHECKSUM_EN
      if (ok) exp_done++;
      send_byte(cks, 1'b0, 4'd0);
`endif
      in_valid = 1'b0;
      if (ok) begin
         repeat (3) @(posedge clk);
         #1;
         chk("end_cpu_res", cpu_res, 1'b0);
         chk("end_busy", busy, 1'b0);
         chk("end_ready", in_ready, 1'b0);
         chk("end_sb_empty", sb_q.size(), 0);
         chk("end_done_seen", exp_done, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      res = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      o_start = 1'b0; o_in_valid = 1'b0; o_in_data = 8'h00;
      img = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      // Reset state, with start asserted together with res
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_cpu_res", cpu_res, 1'b1);
      chk("rst_addr", ram_addr, 4'd0);
      chk("rst_wdata", ram_wdata, 8'h00);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; res = 1'b0;
      @(posedge clk); #1;
      chk("start_with_res_busy", busy, 1'b0);
      chk("idle_cpu_res", cpu_res, 1'b0);

      // Test 1: full image, in_valid held high (image sum 0x1E -> checksum 0xE2)
      do_start();
      load_full(-1, -1, 8'hE2, 1'b1);

      // Test 2: 5-cycle stall before byte 3
      do_start();
      load_full(3, -1, 8'hE2, 1'b1);

      // Test 3: start pulsed during the load at byte 7
      do_start();
      load_full(-1, 7, 8'hE2, 1'b1);

      // Test 4: asynchronous reset after byte 10
      do_start();
      for (int i = 0; i <= 10; i++) begin
         send_byte(img[i], 1'b1, 4'(i));
         in_valid = 1'b0;
      end
      @(posedge clk);
      #3 res = 1'b1;
      #1;
      chk("abort_ready", in_ready, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_cpu_res", cpu_res, 1'b1);
      chk("abort_we", ram_we, 1'b0);
      @(posedge clk); #1;
      res = 1'b0;
      @(posedge clk); #1;
      chk("abort_cpu_release", cpu_res, 1'b0);
      chk("abort_done_none", done, 1'b0);
      do_start();
      load_full(-1, -1, 8'hE2, 1'b1);

`ifdef CHECKSUM_EN
      // Test 5: image sum 0x37; good checksum 0xC9, bad 0xC8
      img[5] = 8'h19;
      do_start();
      load_full(-1, -1, 8'hC9, 1'b1);
      chk("cks_ok_err", err, 1'b0);
      do_start();
      load_full(-1, -1, 8'hC8, 1'b0);
      repeat (25) begin
         chk("cks_bad_err", err, 1'b1);
         chk("cks_bad_cpu_res", cpu_res, 1'b1);
         chk("cks_bad_busy", busy, 1'b0);
         @(posedge clk); #1;
      end
      do_start();
      load_full(-1, -1, 8'hC9, 1'b1);
`endif

      // Test 6: WORDS=1 instance
      o_start = 1'b1;
      @(posedge clk); #1;
      o_start = 1'b0;
      o_in_valid = 1'b1;
      o_in_data  = 8'hF0;
      chk("one_ready", o_in_ready, 1'b1);
      @(posedge clk); #1;
      chk("one_we", o_ram_we, 1'b1);
      chk("one_addr", o_ram_addr, 4'd0);
      chk("one_data", o_ram_wdata, 8'hF0);
      chk("one_cpu_res_load", o_cpu_res, 1'b1);
`ifdef CHECKSUM_EN
      o_in_data = 8'h10;
      @(posedge clk); #1;
      chk("one_chk_ready", o_in_ready, 1'b1);
      @(posedge clk); #1;
      o_in_valid = 1'b0;
`else
      o_in_valid = 1'b0;
      @(posedge clk); #1;
`endif
      chk("one_done", o_done, 1'b1);
      chk("one_no_we", o_ram_we, 1'b0);
      chk("one_err", o_err, 1'b0);
      @(posedge clk); #1;
      chk("one_cpu_release", o_cpu_res, 1'b0);
      chk("one_done_drop", o_done, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("final_sb_empty", sb_q.size(), 0);
      chk("final_done_seen", exp_done, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
